n64_si_eeprom_ctrl: RTL and testbench
=====================================

// Module: n64_si_eeprom_ctrl
// PURPOSE
// Joybus EEPROM responder. Sequences the n64_si shifter via its if_si cpu modport: decodes received frames, fetches or stores
// save data through a byte-wide memory port, loads the reply into the shifter and starts TX.
// Sits between n64_si and the save-memory arbiter.
// PARAMETERS
// ID_4K   8'h80  type byte returned in the info reply when eeprom_16k=0
// ID_16K  8'hC0  type byte returned in the info reply when eeprom_16k=1
// PORTS
// sys.clk        in   1   system clock
// sys.reset      in   1   synchronous, active-high reset
// eeprom_enable  in   1   0: every frame dropped, no reply
// eeprom_16k     in   1   0: 4 kbit (64 blocks), 1: 16 kbit (256 blocks)
// si.rx_reset    out  1   1-cycle pulse: clear n64_si RX state/length
// si.rx_ready    in   1   frame complete (bus idle after >=1 bit)
// si.rx_length   in   7   received bit count
// si.rx_data     in   81  shift register; first bit at rx_data[rx_length-1]
// si.tx_reset    out  1   constant 0
// si.tx_start    out  1   1-cycle pulse: start TX
// si.tx_busy     in   1   TX in progress; rises the cycle after tx_start
// si.tx_wmask    out  3   word write enables: [0]->data[80:49], [1]->[48:17], [2]->[16:0]
// si.tx_length   out  7   reply data bits (stop bit appended by n64_si)
// si.tx_data     out  32  word written under tx_wmask
// mem_req        out  1   byte access request, held until mem_ack
// mem_write      out  1   1: write, 0: read; stable while mem_req
// mem_address    out  11  byte address {block,offset[2:0]}; stable while mem_req
// mem_wdata      out  8   write byte
// mem_ack        in   1   1-cycle completion; mem_rdata valid in same cycle
// mem_rdata      in   8   read byte
// BEHAVIOUR
// - Reset values: all pulses/strobes 0, tx_wmask 0, tx_length 0, mem_req 0, state S_IDLE. Reset mid-operation aborts at once;
//   no further mem or TX activity.
// - States: S_IDLE -> S_DECODE -> (S_MEM) -> S_LOAD -> S_START -> S_WAIT_TX -> S_IDLE.
// - S_IDLE: wait rx_ready=1 and tx_busy=0, then go to S_DECODE.
// - S_DECODE (1 cycle): pulse rx_reset. Latch cmd, block and data[63:0] into an internal 64-bit buffer. Decode:
//   * cmd 8'h00 or 8'hFF, rx_length=8: info.
//   * cmd 8'h04, rx_length=16: read. Block = rx_data[7:0].
//   * cmd 8'h05, rx_length=80: write. Block = rx_data[71:64], data = rx_data[63:0], MSB byte first.
//   * Any other cmd/length pair, or eeprom_enable=0: drop and return to S_IDLE with no TX.
// - Block masked to [5:0] when eeprom_16k=0 (wraps at 64); mem_address = {block,offset}, so address[10:9]=0 in 4k mode.
// - S_MEM: 8 sequential byte accesses, offset 0..7, one outstanding.
//   * mem_req drops the cycle after mem_ack; the next request follows no earlier than one cycle later.
//   * Read: byte n goes to buffer[63-8n -: 8].
//   * Write: mem_wdata = buffer[63-8n -: 8].
// - S_LOAD: drives the shifter words.
//   * Info: 1 cycle, tx_wmask=001, tx_data={8'h00,type,8'h00,8'h00}, tx_length=24.
//   * Read: 2 cycles, wmask 001 with buffer[63:32], then wmask 010 with buffer[31:0]; tx_length=64.
//   * Write: 1 cycle, wmask 001, tx_data=32'h0; tx_length=8.
// - S_START: pulse tx_start; tx_length held from S_LOAD until S_IDLE. S_WAIT_TX: wait tx_busy=0, then S_IDLE.
// - New frames cannot arrive during TX (n64_si ignores RX while tx_busy); rx_ready rising in S_WAIT_TX is handled after return to S_IDLE.
// - Total TX bits = tx_length+1 (stop bit); n64_si sends MSB (data[80]) first.
// TESTING
// - Info: rx_length=8, rx_data=8'h00, eeprom_16k=1 -> one rx_reset; wmask=001, tx_data=32'h00C00000, tx_length=24; no mem_req.
// - Read: 4k, rx 16'h04_41 -> 8 reads at 0x008..0x00F (block masked to 1); mem returns 11..88 ->
//   tx words 32'h11223344, 32'h55667788; tx_length=64.
// - Write: 16k, rx 80'h05_FF_0102030405060708 -> writes 0x7F8..0x7FF with bytes 01..08; reply tx_length=8, data 8'h00.
// - Drop: cmd 8'h04 with rx_length=8, cmd 8'h07, or eeprom_enable=0 -> rx_reset pulse only; no tx_start, no mem_req.
// - Reset mid-read after 3 acks -> mem_req=0 next cycle, no tx_start; next info frame answered normally.
// - Slow memory: ack delayed 20 cycles per byte -> address/req stable throughout; reply identical to fast case.

Source files
------------

// File: rtl/n64_si_eeprom_ctrl.sv
// Joybus EEPROM responder: decodes frames captured by the n64_si shifter, moves save data
// through a byte-wide memory port and loads/starts the reply transmission.
module n64_si_eeprom_ctrl #(
    parameter logic [7:0] ID_4K  = 8'h80,
    parameter logic [7:0] ID_16K = 8'hC0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        eeprom_enable,
    input  logic        eeprom_16k,
    output logic        rx_reset,
    input  logic        rx_ready,
    input  logic [6:0]  rx_length,
    input  logic [80:0] rx_data,
    output logic        tx_reset,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic [2:0]  tx_wmask,
    output logic [6:0]  tx_length,
    output logic [31:0] tx_data,
    output logic        mem_req,
    output logic        mem_write,
    output logic [10:0] mem_address,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_MEM, S_LOAD, S_START, S_WAIT_TX
    } state_t;

    typedef enum logic [1:0] {
        OP_INFO, OP_READ, OP_WRITE
    } op_t;

    state_t      state;
    op_t         op;
    logic [7:0]  block;
    logic [63:0] buffer;
    logic [2:0]  offset;
    logic        second_word;

    logic        is_info;
    logic        is_read;
    logic        is_write;
    logic [7:0]  raw_block;
    logic [7:0]  masked_block;
    logic [5:0]  byte_lsb;
    logic        unused_rx_msb;

    assign tx_reset      = 1'b0;
    assign unused_rx_msb = rx_data[80];

    // The command byte sits at the top of the received bits, so its position depends on length.
    assign is_info      = (rx_length == 7'd8) && ((rx_data[7:0] == 8'h00) || (rx_data[7:0] == 8'hFF));
    assign is_read      = (rx_length == 7'd16) && (rx_data[15:8] == 8'h04);
    assign is_write     = (rx_length == 7'd80) && (rx_data[79:72] == 8'h05);
    assign raw_block    = is_write ? rx_data[71:64] : rx_data[7:0];
    assign masked_block = eeprom_16k ? raw_block : {2'b00, raw_block[5:0]};
    assign byte_lsb     = {~offset, 3'b000};

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            op          <= OP_INFO;
            rx_reset    <= 1'b0;
            tx_start    <= 1'b0;
            tx_wmask    <= 3'b000;
            tx_length   <= 7'd0;
            mem_req     <= 1'b0;
            mem_write   <= 1'b0;
            offset      <= 3'd0;
            second_word <= 1'b0;
        end else begin
            rx_reset <= 1'b0;
            tx_start <= 1'b0;
            tx_wmask <= 3'b000;
            case (state)
                S_IDLE: begin
                    if (rx_ready && !tx_busy) begin
                        rx_reset <= 1'b1;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    offset      <= 3'd0;
                    second_word <= 1'b0;
                    if (!eeprom_enable) begin
                        state <= S_IDLE;
                    end else if (is_info) begin
                        op        <= OP_INFO;
                        tx_wmask  <= 3'b001;
                        tx_length <= 7'd24;
                        state     <= S_LOAD;
                    end else if (is_read) begin
                        op        <= OP_READ;
                        mem_write <= 1'b0;
                        state     <= S_MEM;
                    end else if (is_write) begin
                        op        <= OP_WRITE;
                        mem_write <= 1'b1;
                        state     <= S_MEM;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                // A request is only raised from an idle request line, which guarantees one
                // low cycle between the end of one access and the start of the next.
                S_MEM: begin
                    if (!mem_req) begin
                        mem_req <= 1'b1;
                    end else if (mem_ack) begin
                        mem_req <= 1'b0;
                        offset  <= offset + 3'd1;
                        if (offset == 3'd7) begin
                            tx_wmask  <= 3'b001;
                            tx_length <= (op == OP_READ) ? 7'd64 : 7'd8;
                            state     <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (op == OP_READ && !second_word) begin
                        second_word <= 1'b1;
                        tx_wmask    <= 3'b010;
                    end else begin
                        tx_start <= 1'b1;
                        state    <= S_START;
                    end
                end
                S_START: state <= S_WAIT_TX;
                S_WAIT_TX: begin
                    if (!tx_busy) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Datapath registers carry no reset; they are always written before being used.
    always_ff @(posedge clk) begin
        case (state)
            S_DECODE: begin
                block   <= masked_block;
                buffer  <= rx_data[63:0];
                tx_data <= {8'h00, (eeprom_16k ? ID_16K : ID_4K), 16'h0000};
            end
            S_MEM: begin
                if (!mem_req) begin
                    mem_address <= {block, offset};
                    mem_wdata   <= buffer[byte_lsb +: 8];
                end else if (mem_ack) begin
                    if (op == OP_READ) buffer[byte_lsb +: 8] <= mem_rdata;
                    tx_data <= (op == OP_READ) ? buffer[63:32] : 32'h0000_0000;
                end
            end
            S_LOAD: tx_data <= buffer[31:0];
            default: ;
        endcase
    end

endmodule

// File: tb/tb_n64_si_eeprom_ctrl.sv
// Scoreboard bench for n64_si_eeprom_ctrl: behavioural memory and shifter models pop
// expected accesses and replies as the DUT produces them.
module tb_n64_si_eeprom_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        eeprom_enable = 1'b0;
    logic        eeprom_16k = 1'b0;
    logic        rx_reset;
    logic        rx_ready = 1'b0;
    logic [6:0]  rx_length = 7'd0;
    logic [80:0] rx_data = '0;
    logic        tx_reset;
    logic        tx_start;
    logic        tx_busy = 1'b0;
    logic [2:0]  tx_wmask;
    logic [6:0]  tx_length;
    logic [31:0] tx_data;
    logic        mem_req;
    logic        mem_write;
    logic [10:0] mem_address;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;

    always #5 clk = ~clk;

    n64_si_eeprom_ctrl dut (
        .clk(clk), .reset(reset), .eeprom_enable(eeprom_enable), .eeprom_16k(eeprom_16k),
        .rx_reset(rx_reset), .rx_ready(rx_ready), .rx_length(rx_length), .rx_data(rx_data),
        .tx_reset(tx_reset), .tx_start(tx_start), .tx_busy(tx_busy), .tx_wmask(tx_wmask),
        .tx_length(tx_length), .tx_data(tx_data), .mem_req(mem_req), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        wr;
        logic [10:0] addr;
        logic [7:0]  wdata;
    } mem_exp_t;

    typedef struct {
        logic [6:0]  len;
        logic [31:0] w0;
        logic [31:0] w1;
        logic        chk1;
    } tx_exp_t;

    mem_exp_t    mem_q[$];
    tx_exp_t     tx_q[$];
    logic [7:0]  mem [0:2047];
    int          checks = 0;
    int          failures = 0;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    int          busy_cnt = 0;
    int          n_rxr = 0;
    int          n_start = 0;
    int          n_ack = 0;
    logic [10:0] req_addr = '0;
    logic [31:0] cap0 = '0;
    logic [31:0] cap1 = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Shifter and memory models, sampled on the inactive edge.
    always @(negedge clk) begin : models
        tx_exp_t  te;
        mem_exp_t me;
        if (rx_reset) n_rxr++;
        if (tx_wmask[0]) cap0 = tx_data;
        if (tx_wmask[1]) cap1 = tx_data;
        if (tx_start) begin
            n_start++;
            busy_cnt = 6;
            tx_busy  = 1'b1;
            check("tx_pending", 64'(tx_q.size() > 0), 64'd1);
            if (tx_q.size() > 0) begin
                te = tx_q.pop_front();
                check("tx_length", 64'(tx_length), 64'(te.len));
                check("tx_word0", 64'(cap0), 64'(te.w0));
                if (te.chk1) check("tx_word1", 64'(cap1), 64'(te.w1));
            end
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) tx_busy = 1'b0;
        end

        if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (mem_req) begin
            if (wait_cnt == 0) req_addr = mem_address;
            if (wait_cnt >= ack_delay) begin
                wait_cnt = 0;
                mem_ack  = 1'b1;
                n_ack++;
                if (ack_delay > 0) check("addr_stable", 64'(mem_address), 64'(req_addr));
                check("mem_pending", 64'(mem_q.size() > 0), 64'd1);
                if (mem_q.size() > 0) begin
                    me = mem_q.pop_front();
                    check("mem_write", 64'(mem_write), 64'(me.wr));
                    check("mem_addr", 64'(mem_address), 64'(me.addr));
                    if (me.wr) check("mem_wdata", 64'(mem_wdata), 64'(me.wdata));
                end
                if (mem_write) mem[mem_address] = mem_wdata;
                else mem_rdata = mem[mem_address];
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic exp_read(input logic [10:0] base);
        mem_exp_t m;
        for (int i = 0; i < 8; i++) begin
            m.wr = 1'b0; m.addr = base + 11'(i); m.wdata = 8'h00;
            mem_q.push_back(m);
        end
    endtask

    task automatic exp_write(input logic [10:0] base, input logic [63:0] data);
        mem_exp_t m;
        for (int i = 0; i < 8; i++) begin
            m.wr = 1'b1; m.addr = base + 11'(i); m.wdata = 8'(data >> (56 - 8 * i));
            mem_q.push_back(m);
        end
    endtask

    task automatic exp_tx(input logic [6:0] len, input logic [31:0] w0, input logic [31:0] w1,
                          input logic chk1);
        tx_exp_t t;
        t.len = len; t.w0 = w0; t.w1 = w1; t.chk1 = chk1;
        tx_q.push_back(t);
    endtask

    task automatic present_frame(input logic [6:0] len, input logic [80:0] data);
        @(negedge clk);
        rx_length = len;
        rx_data   = data;
        rx_ready  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rx_reset) break;
        end
        rx_ready = 1'b0;
    endtask

    task automatic run_case(input string tag, input logic [6:0] len, input logic [80:0] data,
                            input int exp_start, input int exp_acks, input int budget);
        int b_rxr, b_start, b_ack;
        b_rxr = n_rxr; b_start = n_start; b_ack = n_ack;
        present_frame(len, data);
        repeat (budget) @(negedge clk);
        check({tag, "_rx_reset"}, 64'(n_rxr - b_rxr), 64'd1);
        check({tag, "_tx_start"}, 64'(n_start - b_start), 64'(exp_start));
        check({tag, "_acks"}, 64'(n_ack - b_ack), 64'(exp_acks));
        check({tag, "_memq_left"}, 64'(mem_q.size()), 64'd0);
        check({tag, "_txq_left"}, 64'(tx_q.size()), 64'd0);
    endtask

    initial begin
        int b_start, b_ack;
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        for (int i = 0; i < 8; i++) mem[8 + i] = 8'(8'h11 * (i + 1));

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rx_reset", 64'(rx_reset), 64'd0);
        check("rst_tx_start", 64'(tx_start), 64'd0);
        check("rst_tx_wmask", 64'(tx_wmask), 64'd0);
        check("rst_tx_length", 64'(tx_length), 64'd0);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_tx_reset", 64'(tx_reset), 64'd0);
        reset = 1'b0;
        eeprom_enable = 1'b1;

        eeprom_16k = 1'b1;
        exp_tx(7'd24, 32'h00C0_0000, 32'h0, 1'b0);
        run_case("info16k", 7'd8, 81'h00, 1, 0, 30);

        eeprom_16k = 1'b0;
        exp_tx(7'd24, 32'h0080_0000, 32'h0, 1'b0);
        run_case("info4k", 7'd8, 81'hFF, 1, 0, 30);

        exp_read(11'h008);
        exp_tx(7'd64, 32'h1122_3344, 32'h5566_7788, 1'b1);
        run_case("read4k", 7'd16, 81'h0441, 1, 8, 80);

        eeprom_16k = 1'b1;
        exp_write(11'h7F8, 64'h0102_0304_0506_0708);
        exp_tx(7'd8, 32'h0, 32'h0, 1'b0);
        run_case("write16k", 7'd80, 81'h05FF_0102_0304_0506_0708, 1, 8, 80);

        exp_read(11'h7F8);
        exp_tx(7'd64, 32'h0102_0304, 32'h0506_0708, 1'b1);
        run_case("readback16k", 7'd16, 81'h04FF, 1, 8, 80);

        run_case("drop_len", 7'd8, 81'h04, 0, 0, 20);
        run_case("drop_cmd", 7'd8, 81'h07, 0, 0, 20);
        eeprom_enable = 1'b0;
        run_case("drop_disabled", 7'd8, 81'h00, 0, 0, 20);
        eeprom_enable = 1'b1;

        eeprom_16k = 1'b0;
        exp_read(11'h008);
        exp_tx(7'd64, 32'h1122_3344, 32'h5566_7788, 1'b1);
        b_start = n_start; b_ack = n_ack;
        present_frame(7'd16, 81'h0441);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (n_ack - b_ack >= 3) break;
        end
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_mem_req", 64'(mem_req), 64'd0);
        mem_q.delete();
        tx_q.delete();
        repeat (40) @(negedge clk);
        check("midrst_acks", 64'(n_ack - b_ack), 64'd3);
        check("midrst_tx_start", 64'(n_start - b_start), 64'd0);
        check("midrst_mem_req_idle", 64'(mem_req), 64'd0);

        eeprom_16k = 1'b1;
        exp_tx(7'd24, 32'h00C0_0000, 32'h0, 1'b0);
        run_case("info_after_rst", 7'd8, 81'h00, 1, 0, 30);

        eeprom_16k = 1'b0;
        ack_delay = 20;
        exp_read(11'h008);
        exp_tx(7'd64, 32'h1122_3344, 32'h5566_7788, 1'b1);
        run_case("slow_read", 7'd16, 81'h0441, 1, 8, 260);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
